// File: rtl/puf_eval_ctrl.sv
// Arbiter-PUF evaluation sequencer: N_EVAL settle/fire/sample rounds, then a per-lane majority vote.
// Build option: define PUF_EVAL_STABILITY_EN to produce the per-lane unstable flags (otherwise tied to 0).
module puf_eval_ctrl #(
    parameter int N_EVAL     = 5,
    parameter int SETTLE_CYC = 4,
    parameter int PULSE_CYC  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       start,
    input  logic [7:0] challenge,
    input  logic [7:0] puf_resp,
    output logic [7:0] puf_challenge,
    output logic       puf_pulse,
    output logic       busy,
    output logic       done,
    output logic [7:0] response,
    output logic [7:0] unstable
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_FIRE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);
    localparam logic [7:0] PULSE_LAST  = 8'(PULSE_CYC - 1);
    localparam logic [3:0] N_EVAL_W    = 4'(N_EVAL);
    localparam logic [3:0] HALF_W      = 4'(N_EVAL / 2);

    state_t     state_reg, state_next;
    logic [7:0] timer_reg, timer_next;
    logic [3:0] eval_reg, eval_next;
    logic [7:0] chal_reg, chal_next;
    logic [3:0] votes_reg [8];
    logic       vote_clr, vote_add, result_load;
    logic [7:0] resp_bit_next;
    logic [7:0] response_reg;
    logic       done_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            timer_reg <= 8'd0;
            eval_reg  <= 4'd0;
            chal_reg  <= 8'd0;
        end else begin
            state_reg <= state_next;
            timer_reg <= timer_next;
            eval_reg  <= eval_next;
            chal_reg  <= chal_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        timer_next  = timer_reg;
        eval_next   = eval_reg;
        chal_next   = chal_reg;
        vote_clr    = 1'b0;
        vote_add    = 1'b0;
        result_load = 1'b0;
        // Dropping ena outranks every in-flight state, including DONE, so an abort never strobes done.
        if (state_reg != ST_IDLE && !ena) begin
            state_next = ST_IDLE;
            timer_next = 8'd0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start && ena) begin
                        chal_next  = challenge;
                        vote_clr   = 1'b1;
                        eval_next  = 4'd0;
                        timer_next = 8'd0;
                        state_next = ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (timer_reg == SETTLE_LAST) begin
                        timer_next = 8'd0;
                        state_next = ST_FIRE;
                    end else begin
                        timer_next = timer_reg + 8'd1;
                    end
                end
                ST_FIRE: begin
                    if (timer_reg == PULSE_LAST) begin
                        timer_next = 8'd0;
                        state_next = ST_SAMPLE;
                    end else begin
                        timer_next = timer_reg + 8'd1;
                    end
                end
                ST_SAMPLE: begin
                    vote_add   = 1'b1;
                    eval_next  = eval_reg + 4'd1;
                    timer_next = 8'd0;
                    state_next = (eval_next == N_EVAL_W) ? ST_DONE : ST_SETTLE;
                end
                ST_DONE: begin
                    result_load = 1'b1;
                    state_next  = ST_IDLE;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Per-lane vote counters; 4 bits cannot wrap because N_EVAL is at most 15.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_lane
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    votes_reg[gi] <= 4'd0;
                end else if (vote_clr) begin
                    votes_reg[gi] <= 4'd0;
                end else if (vote_add) begin
                    votes_reg[gi] <= votes_reg[gi] + {3'd0, puf_resp[gi]};
                end
            end
            assign resp_bit_next[gi] = (votes_reg[gi] > HALF_W);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            response_reg <= 8'd0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= result_load;
            if (result_load) begin
                response_reg <= resp_bit_next;
            end
        end
    end

`ifdef PUF_EVAL_STABILITY_EN
    logic [7:0] unst_bit_next;
    logic [7:0] unstable_reg;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_stab
            assign unst_bit_next[gi] = (votes_reg[gi] != 4'd0) && (votes_reg[gi] != N_EVAL_W);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            unstable_reg <= 8'd0;
        end else if (result_load) begin
            unstable_reg <= unst_bit_next;
        end
    end

    assign unstable = unstable_reg;
`else
    assign unstable = 8'h00;
`endif

    assign puf_challenge = chal_reg;
    assign puf_pulse     = (state_reg == ST_FIRE);
    assign busy          = (state_reg != ST_IDLE);
    assign done          = done_reg;
    assign response      = response_reg;

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// Scoreboard bench for puf_eval_ctrl (default parameters); unstable expectations follow PUF_EVAL_STABILITY_EN.
module tb_puf_eval_ctrl;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       start;
    logic [7:0] challenge;
    logic [7:0] puf_resp;
    logic [7:0] puf_challenge;
    logic       puf_pulse;
    logic       busy;
    logic       done;
    logic [7:0] response;
    logic [7:0] unstable;

`ifdef PUF_EVAL_STABILITY_EN
    localparam logic [7:0] NOISY_UNST = 8'h01;
`else
    localparam logic [7:0] NOISY_UNST = 8'h00;
`endif
    localparam int LATENCY = 36;

    typedef struct packed {
        logic [7:0] resp;
        logic [7:0] unst;
        logic [7:0] chal;
    } exp_t;

    exp_t       sb_q [$];
    int         checks_cnt   = 0;
    int         failures_cnt = 0;
    bit         noisy_mode   = 0;
    logic [4:0] noise_pat    = 5'b01101;   // bit0 samples 1,0,1,1,0 over the five rounds

    puf_eval_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ena           (ena),
        .start         (start),
        .challenge     (challenge),
        .puf_resp      (puf_resp),
        .puf_challenge (puf_challenge),
        .puf_pulse     (puf_pulse),
        .busy          (busy),
        .done          (done),
        .response      (response),
        .unstable      (unstable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            failures_cnt++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_pulse"}, puf_pulse, 0);
        chk({tag, "_chal"}, puf_challenge, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_resp"}, response, 0);
        chk({tag, "_unst"}, unstable, 0);
    endtask

    // One request. abort_at<0: normal run, done expected at LATENCY; otherwise ena drops at that cycle
    // and resp_exp/unst_exp are the previous results that must be retained.
    task automatic run_req(input logic [7:0] chal, input logic [7:0] resp_exp, input logic [7:0] unst_exp,
                           input int stray_a, input int stray_b, input int abort_at, input bit pre_driven);
        int   done_cnt  = 0;
        int   done_cyc  = -1;
        int   pulse_err = 0;
        int   busy_err  = 0;
        int   chal_err  = 0;
        int   rises     = 0;
        logic prev_pulse = 1'b0;
        logic exp_busy, exp_pulse;
        exp_t e;
        if (!pre_driven) begin
            @(negedge clk);
            challenge = chal;
            start     = 1'b1;
        end
        @(posedge clk);
        if (abort_at < 0) sb_q.push_back({resp_exp, unst_exp, chal});
        #1;
        start     = 1'b0;
        challenge = ~chal;
        for (int cyc = 0; cyc < 48; cyc++) begin
            @(negedge clk);
            if (abort_at < 0) begin
                exp_busy  = (cyc < LATENCY);
                exp_pulse = (cyc < LATENCY - 1) && ((cyc % 7 == 4) || (cyc % 7 == 5));
            end else begin
                exp_busy  = (cyc <= abort_at);
                exp_pulse = (cyc <= abort_at) && ((cyc % 7 == 4) || (cyc % 7 == 5));
            end
            if (busy !== exp_busy) busy_err++;
            if (puf_pulse !== exp_pulse) pulse_err++;
            if (busy && puf_challenge !== chal) chal_err++;
            if (puf_pulse && !prev_pulse) rises++;
            prev_pulse = puf_pulse;
            if (noisy_mode && rises > 0 && rises <= 5) puf_resp = {7'd0, noise_pat[rises-1]};
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    done_cyc = cyc;
                    if (sb_q.size() == 0) begin
                        chk("sb_unexpected_done", 1, 0);
                    end else begin
                        e = sb_q.pop_front();
                        $display("txn chal=%02h resp=%02h unst=%02h latency=%0d", puf_challenge, response, unstable, cyc);
                        chk("latency", cyc, LATENCY);
                        chk("response", response, e.resp);
                        chk("unstable", unstable, e.unst);
                        chk("puf_challenge", puf_challenge, e.chal);
                    end
                end
            end
            ena   = (abort_at >= 0 && cyc >= abort_at && cyc <= abort_at + 1) ? 1'b0 : 1'b1;
            start = (cyc == stray_a || cyc == stray_b) ? 1'b1 : 1'b0;
        end
        ena   = 1'b1;
        start = 1'b0;
        chk("busy_wave", busy_err, 0);
        chk("pulse_wave", pulse_err, 0);
        chk("chal_hold", chal_err, 0);
        chk("pulse_rises", rises, (abort_at < 0) ? 5 : 3);
        chk("done_count", done_cnt, (abort_at < 0) ? 1 : 0);
        if (abort_at >= 0) begin
            $display("txn chal=%02h aborted resp=%02h unst=%02h", chal, response, unstable);
            chk("abort_resp_kept", response, resp_exp);
            chk("abort_unst_kept", unstable, unst_exp);
        end
        chk("sb_empty", sb_q.size(), 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        ena       = 1'b1;
        start     = 1'b0;
        challenge = 8'h00;
        puf_resp  = 8'h00;
        repeat (3) @(posedge clk);
        #2;
        chk_all_zero("por");
        rst_n = 1'b1;

        // Stable PUF, defaults
        puf_resp = 8'hA5;
        run_req(8'h3C, 8'hA5, 8'h00, -1, -1, -1, 0);

        // Stray starts at cycle 10 and in the DONE cycle
        puf_resp = 8'h5A;
        run_req(8'hC3, 8'h5A, 8'h00, 10, LATENCY - 1, -1, 0);

        puf_resp = 8'($urandom_range(0, 255));
        run_req(8'h96, puf_resp, 8'h00, -1, -1, -1, 0);

        // Noisy lane 0
        noisy_mode = 1;
        puf_resp   = 8'h00;
        run_req(8'h77, 8'h01, NOISY_UNST, -1, -1, -1, 0);
        noisy_mode = 0;

        // ena dropped during the 3rd FIRE (cycle 18); previous results must stay
        puf_resp = 8'hFF;
        run_req(8'h42, 8'h01, NOISY_UNST, -1, -1, 18, 0);

        // Asynchronous reset mid-SETTLE, then a start on the first edge after release
        puf_resp = 8'h0F;
        @(negedge clk);
        challenge = 8'h99;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        challenge = 8'h11;
        start     = 1'b1;
        #2 rst_n = 1'b1;
        run_req(8'h11, 8'h0F, 8'h00, -1, -1, -1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, failures_cnt);
        $finish;
    end

endmodule
